// File: rtl/sram_like_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_pkg
// Shared encodings for the sram-like 2x1 arbiter: transfer sizes, master IDs
// and the bundled address-phase payload used by the slave-side mux.
// -----------------------------------------------------------------------------
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // The 1-bit master ID is also the value stored in the grant-order FIFO.
  typedef enum logic {
    MST_INST = 1'b0,
    MST_DATA = 1'b1
  } mst_e;

  // Everything that travels with an address phase.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_payload_t;

endpackage

// File: rtl/sram_like_arbiter_2x1_order_fifo.sv
// -----------------------------------------------------------------------------
// order_fifo
// Small synchronous FIFO recording which master owns each accepted but not
// yet completed transaction. Push and pop may occur in the same cycle at any
// fill level; a push while full or a pop while empty is ignored.
//
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   push, din      write one entry
//   pop, dout      dout is the head entry; pop discards it
//   full, empty    status flags
//   count          number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module order_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it has been written, and the empty flag comes from the reset count.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_like_arbiter_2x1.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter_2x1
// Shares one sram-like slave port between an instruction master (inst_*) and
// a data master (data_*). Address phases are granted combinationally (lock,
// then single requester, then round-robin); the grant order is recorded in
// order_fifo so each slave data_ok/rdata is returned to the right master.
//
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   inst_* / data_*       sram-like master ports (req, wr, size, addr, wdata
//                         in; rdata, addr_ok, data_ok out)
//   m_*                   sram-like slave port (req, wr, size, addr, wdata
//                         out; rdata, addr_ok, data_ok in)
// -----------------------------------------------------------------------------
module sram_like_arbiter_2x1
  import sram_like_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int PTR_W           = 2
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  mst_e         sel;
  mst_e         rr_last;
  mst_e         lock_sel;
  logic         lock_valid;
  logic         sel_req;
  logic         addr_done;
  req_payload_t inst_pl;
  req_payload_t data_pl;
  req_payload_t sel_pl;

  logic         fifo_full;
  logic         fifo_empty;
  logic [PTR_W:0] fifo_count;
  logic         fifo_head;
  mst_e         head_mst;
  logic         ret_valid;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default first keeps this block purely combinational;
    // any path that left sel unassigned would infer a latch.
    sel = MST_INST;
    if (lock_valid) begin
      sel = lock_sel;
    end else if (inst_req && data_req) begin
      sel = (rr_last == MST_INST) ? MST_DATA : MST_INST;
    end else if (data_req) begin
      sel = MST_DATA;
    end
  end

  assign inst_pl = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_pl = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
  assign sel_pl  = (sel == MST_DATA) ? data_pl : inst_pl;
  assign sel_req = (sel == MST_DATA) ? data_req : inst_req;

  // A full FIFO blocks new address phases even if a pop frees a slot this
  // cycle; the request re-enables on the following cycle.
  assign m_req     = aresetn && sel_req && !fifo_full;
  assign m_wr      = sel_pl.wr;
  assign m_size    = sel_pl.size;
  assign m_addr    = sel_pl.addr;
  assign m_wdata   = sel_pl.wdata;
  assign addr_done = m_req && m_addr_ok;

  assign inst_addr_ok = addr_done && (sel == MST_INST);
  assign data_addr_ok = addr_done && (sel == MST_DATA);

  // ---------------------------------------------------------------------------
  // Lock and round-robin state
  // ---------------------------------------------------------------------------
  // A presented but unaccepted address phase keeps the grant so the slave
  // never sees the request change under it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock_valid <= 1'b0;
      lock_sel   <= MST_INST;
      rr_last    <= MST_INST;
    end else if (addr_done) begin
      lock_valid <= 1'b0;
      rr_last    <= sel;
    end else if (m_req) begin
      lock_valid <= 1'b1;
      lock_sel   <= sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant-order FIFO and return routing
  // ---------------------------------------------------------------------------
  order_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .PTR_W (PTR_W),
    .WIDTH (1)
  ) u_order_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (addr_done),
    .pop     (ret_valid),
    .din     (sel == MST_DATA),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head_mst = fifo_head ? MST_DATA : MST_INST;

  // A data_ok with nothing outstanding is a slave protocol error: drop it.
  assign ret_valid    = aresetn && m_data_ok && !fifo_empty;
  assign inst_data_ok = ret_valid && (head_mst == MST_INST);
  assign data_data_ok = ret_valid && (head_mst == MST_DATA);
  assign inst_rdata   = inst_data_ok ? m_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? m_rdata : 32'h0;

  no_return_when_empty : assert property (
    @(posedge aclk) disable iff (!aresetn) m_data_ok |-> (fifo_count != '0)
  );

endmodule

// File: tb/tb_sram_like_arbiter_2x1.sv
// -----------------------------------------------------------------------------
// tb_sram_like_arbiter_2x1
// Directed scenarios followed by randomized traffic. A transaction-level model
// (owner queue, last-winner bit, stalled-owner memory) predicts every output
// each cycle; directed scenarios also pin literal values.
// -----------------------------------------------------------------------------
module tb_sram_like_arbiter_2x1;
  import sram_like_pkg::*;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  sram_like_arbiter_2x1 #(.MAX_OUTSTANDING(MAX_OUT), .PTR_W(2)) dut (
    .aclk(clk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: owners of outstanding transactions in issue
  // order, which master won the last address phase, and which master (if
  // any) is stuck presenting an unaccepted address phase.
  bit mq[$];
  bit last_winner;
  bit stuck_valid;
  bit stuck_owner;

  // Values sampled at the falling edge of the most recent cycle.
  logic        s_m_req;
  logic [31:0] s_m_addr;
  logic        s_inst_addr_ok, s_data_addr_ok, s_inst_data_ok, s_data_data_ok;
  logic [31:0] s_inst_rdata, s_data_rdata;

  task automatic model_reset();
    mq.delete();
    last_winner = 1'b0;
    stuck_valid = 1'b0;
    stuck_owner = 1'b0;
  endtask

  task automatic model_cycle();
    bit g, full, want, accept, ret, owner;
    if (!aresetn) begin
      check("rst m_req", m_req, 0);
      check("rst inst_addr_ok", inst_addr_ok, 0);
      check("rst data_addr_ok", data_addr_ok, 0);
      check("rst inst_data_ok", inst_data_ok, 0);
      check("rst data_data_ok", data_data_ok, 0);
      check("rst inst_rdata", inst_rdata, 0);
      check("rst data_rdata", data_rdata, 0);
      model_reset();
      return;
    end
    // Who is presented to the slave this cycle.
    if (stuck_valid)                g = stuck_owner;
    else if (inst_req && data_req)  g = !last_winner;
    else                            g = data_req;
    full   = (mq.size() == MAX_OUT);
    want   = (g ? data_req : inst_req) && !full;
    accept = want && m_addr_ok;
    ret    = m_data_ok && (mq.size() > 0);
    owner  = ret ? mq[0] : 1'b0;

    check("m_req", m_req, want);
    check("m_wr", m_wr, g ? data_wr : inst_wr);
    check("m_size", m_size, g ? data_size : inst_size);
    check("m_addr", m_addr, g ? data_addr : inst_addr);
    check("m_wdata", m_wdata, g ? data_wdata : inst_wdata);
    check("inst_addr_ok", inst_addr_ok, accept && !g);
    check("data_addr_ok", data_addr_ok, accept && g);
    check("inst_data_ok", inst_data_ok, ret && !owner);
    check("data_data_ok", data_data_ok, ret && owner);
    check("inst_rdata", inst_rdata, (ret && !owner) ? m_rdata : 32'h0);
    check("data_rdata", data_rdata, (ret && owner) ? m_rdata : 32'h0);

    if (ret) void'(mq.pop_front());
    if (accept) begin
      mq.push_back(g);
      last_winner = g;
      stuck_valid = 1'b0;
    end else if (want) begin
      stuck_valid = 1'b1;
      stuck_owner = g;
    end
  endtask

  // Inputs are driven 2 ns after a rising edge; outputs are sampled and
  // compared at the falling edge.
  task automatic cycle();
    @(negedge clk);
    s_m_req        = m_req;
    s_m_addr       = m_addr;
    s_inst_addr_ok = inst_addr_ok;
    s_data_addr_ok = data_addr_ok;
    s_inst_data_ok = inst_data_ok;
    s_data_data_ok = data_data_ok;
    s_inst_rdata   = inst_rdata;
    s_data_rdata   = data_rdata;
    model_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic ret_cycle(input logic [31:0] rd);
    m_data_ok = 1'b1;
    m_rdata   = rd;
    cycle();
    m_data_ok = 1'b0;
  endtask

  bit          ipend, dpend;
  int          slave_out;

  initial begin
    aresetn = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = SZ_WORD; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b1; data_wr = 1'b0; data_size = SZ_WORD; data_addr = 32'h0; data_wdata = 32'h0;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hDEADBEEF;
    model_reset();

    // Reset: everything quiet even with all inputs active.
    cycle();
    check("reset m_req", s_m_req, 0);
    check("reset inst_data_ok", s_inst_data_ok, 0);
    check("reset data_rdata", s_data_rdata, 0);
    cycle();
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    aresetn = 1'b1;
    cycle();

    // Single read.
    inst_req = 1'b1; inst_addr = 32'hBFC00000; m_addr_ok = 1'b1;
    cycle();
    check("single inst_addr_ok", s_inst_addr_ok, 1);
    check("single m_addr", s_m_addr, 32'hBFC00000);
    inst_req = 1'b0; m_addr_ok = 1'b0;
    cycle();
    ret_cycle(32'h3C1D0000);
    check("single inst_data_ok", s_inst_data_ok, 1);
    check("single inst_rdata", s_inst_rdata, 32'h3C1D0000);
    check("single data_data_ok", s_data_data_ok, 0);

    // Simultaneous requests: data wins the tie, inst follows.
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    data_req = 1'b1; data_addr = 32'h80001000; m_addr_ok = 1'b1;
    cycle();
    check("tie data_addr_ok", s_data_addr_ok, 1);
    check("tie inst_addr_ok", s_inst_addr_ok, 0);
    check("tie m_addr first", s_m_addr, 32'h80001000);
    data_req = 1'b0;
    cycle();
    check("tie inst_addr_ok second", s_inst_addr_ok, 1);
    check("tie m_addr second", s_m_addr, 32'hBFC00004);
    inst_req = 1'b0; m_addr_ok = 1'b0;
    ret_cycle(32'h11111111);
    check("tie ret1 data_data_ok", s_data_data_ok, 1);
    check("tie ret1 data_rdata", s_data_rdata, 32'h11111111);
    ret_cycle(32'h22222222);
    check("tie ret2 inst_data_ok", s_inst_data_ok, 1);
    check("tie ret2 inst_rdata", s_inst_rdata, 32'h22222222);

    // Lock hold: inst stalls 3 cycles, data arrives meanwhile.
    inst_req = 1'b1; inst_addr = 32'hBFC00008; m_addr_ok = 1'b0;
    cycle();
    check("lock m_addr c0", s_m_addr, 32'hBFC00008);
    data_req = 1'b1; data_addr = 32'h80002000;
    for (int i = 1; i < 3; i++) begin
      cycle();
      check("lock m_addr", s_m_addr, 32'hBFC00008);
      check("lock data_addr_ok", s_data_addr_ok, 0);
    end
    m_addr_ok = 1'b1;
    cycle();
    check("lock m_addr c3", s_m_addr, 32'hBFC00008);
    check("lock inst_addr_ok", s_inst_addr_ok, 1);
    check("lock data_addr_ok c3", s_data_addr_ok, 0);
    inst_req = 1'b0;
    cycle();
    check("lock data after", s_data_addr_ok, 1);
    data_req = 1'b0; m_addr_ok = 1'b0;
    ret_cycle(32'h00000001);
    ret_cycle(32'h00000002);

    // FIFO full: four data writes, then inst waits until a slot frees.
    data_req = 1'b1; data_wr = 1'b1; m_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_addr = 32'h80003000 + 32'(4 * i);
      data_wdata = 32'hC0DE0000 + 32'(i);
      cycle();
      check("full data_addr_ok", s_data_addr_ok, 1);
    end
    data_req = 1'b0; data_wr = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC0000C;
    cycle();
    check("full m_req", s_m_req, 0);
    check("full inst_addr_ok", s_inst_addr_ok, 0);
    ret_cycle(32'h0);
    check("full pop data_data_ok", s_data_data_ok, 1);
    check("full pop m_req gated", s_m_req, 0);
    cycle();
    check("full reenable m_req", s_m_req, 1);
    check("full reenable inst_addr_ok", s_inst_addr_ok, 1);
    inst_req = 1'b0; m_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) ret_cycle(32'h100 + 32'(i));

    // Interleaved returns: accept data, inst, data, inst.
    m_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_req = (i % 2 == 0);
      inst_req = (i % 2 == 1);
      data_addr = 32'h80004000 + 32'(i);
      inst_addr = 32'hBFC01000 + 32'(i);
      cycle();
      check("ilv addr_ok", (i % 2 == 0) ? s_data_addr_ok : s_inst_addr_ok, 1);
    end
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
    ret_cycle(32'hA);
    check("ilv A data", s_data_rdata, 32'hA);
    ret_cycle(32'hB);
    check("ilv B inst", s_inst_rdata, 32'hB);
    ret_cycle(32'hC);
    check("ilv C data", s_data_rdata, 32'hC);
    ret_cycle(32'hD);
    check("ilv D inst", s_inst_rdata, 32'hD);
    check("ilv D data quiet", s_data_data_ok, 0);

    // Asynchronous reset with two transactions outstanding.
    m_addr_ok = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC02000;
    cycle();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h80005000;
    cycle();
    data_req = 1'b0; inst_req = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h5A5A5A5A;
    #1 aresetn = 1'b0;
    #1;
    check("async m_req", m_req, 0);
    check("async inst_addr_ok", inst_addr_ok, 0);
    check("async data_addr_ok", data_addr_ok, 0);
    check("async inst_data_ok", inst_data_ok, 0);
    check("async data_data_ok", data_data_ok, 0);
    cycle();
    inst_req = 1'b0; m_data_ok = 1'b0; m_addr_ok = 1'b0;
    cycle();
    aresetn = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC03000; m_addr_ok = 1'b1;
    cycle();
    check("post-reset inst_addr_ok", s_inst_addr_ok, 1);
    inst_req = 1'b0; m_addr_ok = 1'b0;
    cycle();
    check("post-reset no stale inst", s_inst_data_ok, 0);
    check("post-reset no stale data", s_data_data_ok, 0);
    ret_cycle(32'h12345678);
    check("post-reset inst_rdata", s_inst_rdata, 32'h12345678);

    // Randomized traffic against the model.
    ipend = 1'b0; dpend = 1'b0; slave_out = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!ipend && ($urandom_range(0, 2) == 0)) begin
        ipend = 1'b1;
        inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 2));
        inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!dpend && ($urandom_range(0, 2) == 0)) begin
        dpend = 1'b1;
        data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom; data_wdata = $urandom;
      end
      inst_req  = ipend;
      data_req  = dpend;
      m_addr_ok = 1'($urandom_range(0, 1));
      m_data_ok = (slave_out > 0) && ($urandom_range(0, 2) != 0);
      m_rdata   = $urandom;
      cycle();
      if (s_inst_addr_ok) ipend = 1'b0;
      if (s_data_addr_ok) dpend = 1'b0;
      slave_out = slave_out - int'(m_data_ok) + int'(s_m_req && m_addr_ok);
    end
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter_2x1.md
Name: sram_like_arbiter_2x1

Overview:
- Shares one sram-like slave port, the cpu_axi_interface data channel, between two sram-like masters: instruction-side (inst_*) and data-side (data_*).
- Arbitrates address phases and records the grant order in an in-order tracking FIFO. Each slave data_ok/rdata is routed back to the master that issued the matching request.
- Sits between the cache/uncached 2x1 bridge layer and the single AXI interface, so that the core can later run with a single-port AXI shim.

Parameters:
- MAX_OUTSTANDING, 4: depth of the grant-order FIFO; maximum number of accepted but not yet completed transactions.
- PTR_W, 2: log2(MAX_OUTSTANDING). MAX_OUTSTANDING must be a power of two, at least 2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction master request
- inst_wr  in  1  write enable (0 = read)
- inst_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr  in  32  physical address
- inst_wdata  in  32  write data
- inst_rdata  out  32  read data
- inst_addr_ok  out  1  address accepted
- inst_data_ok  out  1  data returned / write done
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same widths and meanings, data master
- m_req  out  1  slave request
- m_wr  out  1  slave write enable
- m_size  out  2  slave size
- m_addr  out  32  slave address
- m_wdata  out  32  slave write data
- m_rdata  in  32  slave read data
- m_addr_ok  in  1  slave address accepted
- m_data_ok  in  1  slave data returned

Behaviour:
- Clock and reset: single clock aclk; reset aresetn asynchronous, active-low. All state clears immediately when aresetn falls.
- Reset values: while aresetn is low, m_req, inst_addr_ok, inst_data_ok, data_addr_ok and data_data_ok are 0. inst_rdata and data_rdata are 0. The FIFO is empty, the lock is clear and rr_last = inst (so data wins the first tie).
- Handshake (sram-like):
  - A master holds req and its payload stable until addr_ok.
  - An address phase completes on the cycle where req && addr_ok.
  - data_ok returns in request order, one per accepted request; rdata is valid only with data_ok.
- Grant selection (combinational, zero-cycle pass-through):
  - If lock_valid, sel = lock_sel.
  - Else if exactly one master requests, sel = that master.
  - Else if both request, sel = the master opposite rr_last (round-robin).
- Slave drive:
  - m_req = selected master's req && !fifo_full.
  - m_wr, m_size, m_addr and m_wdata are muxed from sel.
  - The mux is held at inst when nothing is requesting.
- addr_ok routing: sel_addr_ok = m_addr_ok && m_req, returned only to the selected master. The other master's addr_ok is 0.
- Lock:
  - Set when m_req && !m_addr_ok, with lock_valid <= 1 and lock_sel <= sel.
  - Cleared on the cycle m_req && m_addr_ok.
  - While locked, a higher-priority request from the other master does not preempt.
- Round-robin: rr_last <= sel on every completed address phase.
- FIFO:
  - Push sel (1 bit, 1 = data) on each completed address phase.
  - Pop on m_data_ok.
  - The FIFO keeps a count of 0..MAX_OUTSTANDING; pointers wrap modulo MAX_OUTSTANDING.
- Return routing:
  - On m_data_ok, the head entry selects the master: <master>_data_ok = 1 and <master>_rdata = m_rdata.
  - The other master sees data_ok 0 and rdata 0.
- Full FIFO: when count == MAX_OUTSTANDING, m_req is forced to 0 and no addr_ok is issued.
  - If a simultaneous pop frees a slot, m_req is still gated that cycle and is re-enabled the next cycle.
  - Push-after-pop is therefore never needed at full.
- Simultaneous push and pop: count is unchanged, and the head advances correctly even when count == 1.
- Empty FIFO: m_data_ok with count == 0 is a protocol error. Drop it, emit no master data_ok, and flag it with a simulation-only assertion.
- Same-cycle completion: the slave may return data_ok in the same cycle as addr_ok only for an earlier request. A zero-latency return of the current request is not supported; the FIFO head at that cycle determines routing.
- Mid-operation reset: outstanding transactions are discarded without any data_ok. The slave is reset by the same aresetn.

Decomposition:
- Shared package sram_like_pkg:
  - size encodings SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2
  - master IDs MST_INST = 1'b0, MST_DATA = 1'b1
- One natural sub-module: order_fifo.
  - Width 1, depth MAX_OUTSTANDING, ports push/pop/din/dout/full/empty/count.
  - Asynchronous active-low reset on aresetn.
- Top level holds only the arbitration, lock, round-robin and muxing logic.

Test Plan:
- Single read: inst read 0xBFC00000, slave addr_ok in cycle 0, data_ok with 0x3C1D0000 two cycles later -> inst_addr_ok in cycle 0, inst_data_ok and inst_rdata = 0x3C1D0000, data side stays 0.
- Simultaneous requests from reset: both req in the same cycle, slave addr_ok at once -> data granted first, inst granted next cycle. Returns of 0x11111111 then 0x22222222 go to data then inst, in that order.
- Lock hold: inst req, slave addr_ok low for 3 cycles, data req asserted in cycle 1 -> m_addr stays the inst address for all 4 cycles and data_addr_ok stays 0 until inst completes.
- FIFO full: 4 data writes accepted with no data_ok, inst req pending -> m_req = 0, inst_addr_ok = 0. The first m_data_ok pulses data_data_ok, then m_req reasserts the next cycle.
- Interleaved returns: accept order data, inst, data, inst; data_ok order is 4 pulses with rdata 0xA, 0xB, 0xC, 0xD -> data_data_ok gets 0xA and 0xC, inst_data_ok gets 0xB and 0xD.
- Asynchronous reset mid-flight: 2 outstanding, aresetn low between clock edges -> all addr_ok/data_ok = 0 immediately. After release, a new inst read completes normally with no stale data_ok.
